// File: rtl/muldiv_unit_if.sv
// Handshake and write-back bundle between the control path and the muldiv_unit execute block.
interface muldiv_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic                  kill;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] rs1_val;
  logic [DATA_WIDTH-1:0] rs2_val;
  logic [4:0]            rd_in;
  logic                  busy;
  logic                  done;
  logic                  wb_we;
  logic [4:0]            wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;

  modport master (
    output start, kill, funct3, rs1_val, rs2_val, rd_in,
    input  busy, done, wb_we, wb_rd, wb_data
  );

  modport slave (
    input  start, kill, funct3, rs1_val, rs2_val, rd_in,
    output busy, done, wb_we, wb_rd, wb_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed-overflow divides skip the iteration.
module muldiv_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  logic [1:0]              r_state;
  logic [CNT_W-1:0]        r_count;
  logic                    r_fix;
  logic [2*DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0]   r_opb;
  logic [2:0]              r_funct3;
  logic [4:0]              r_rd;
  logic                    r_neg_q;
  logic                    r_neg_r;
  logic                    r_div0;
  logic [DATA_WIDTH-1:0]   r_wb_data;
  logic [4:0]              r_wb_rd;

  logic [1:0]              w_state_d;
  logic [CNT_W-1:0]        w_count_d;
  logic                    w_fix_d;
  logic [2*DATA_WIDTH-1:0] w_acc_d;
  logic                    w_load;
  logic                    w_wb_load;

  // Operand decode on the accepting edge.
  logic                    w_is_div;
  logic                    w_a_signed;
  logic                    w_b_signed;
  logic                    w_a_neg;
  logic                    w_b_neg;
  logic [DATA_WIDTH-1:0]   w_a_mag;
  logic [DATA_WIDTH-1:0]   w_b_mag;
  logic                    w_div0;
  logic                    w_ovf;
  logic                    w_early;
  logic [2*DATA_WIDTH-1:0] w_acc_init;

  assign w_is_div   = bus.funct3[2];
  assign w_a_signed = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd2) ||
                      (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
  assign w_b_signed = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
  assign w_a_neg    = w_a_signed & bus.rs1_val[DATA_WIDTH-1];
  assign w_b_neg    = w_b_signed & bus.rs2_val[DATA_WIDTH-1];
  assign w_a_mag    = w_a_neg ? -bus.rs1_val : bus.rs1_val;
  assign w_b_mag    = w_b_neg ? -bus.rs2_val : bus.rs2_val;
  assign w_div0     = w_is_div & (bus.rs2_val == '0);
  assign w_ovf      = w_is_div & ~bus.funct3[0] & (bus.rs1_val == MinNeg) & (&bus.rs2_val);
  assign w_early    = EarlyOut & (w_div0 | w_ovf);

  // Multiply keeps the multiplier in the low half; divide keeps {remainder, dividend/quotient}.
  // An early divide-by-zero preloads the final {dividend, all-ones} image directly.
  always_comb begin
    w_acc_init = '0;
    if (!w_is_div) begin
      w_acc_init = {{DATA_WIDTH{1'b0}}, w_b_mag};
    end else if (w_early && w_div0) begin
      w_acc_init = {w_a_mag, {DATA_WIDTH{1'b1}}};
    end else begin
      w_acc_init = {{DATA_WIDTH{1'b0}}, w_a_mag};
    end
  end

  // One iteration step of each algorithm.
  logic [DATA_WIDTH:0]     w_mul_sum;
  logic [2*DATA_WIDTH-1:0] w_mul_next;
  logic [DATA_WIDTH:0]     w_div_shift;
  logic [DATA_WIDTH:0]     w_div_diff;
  logic                    w_div_ge;
  logic [DATA_WIDTH-1:0]   w_div_rem;
  logic [2*DATA_WIDTH-1:0] w_div_next;

  assign w_mul_sum   = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]} +
                       (r_acc[0] ? {1'b0, r_opb} : {(DATA_WIDTH+1){1'b0}});
  assign w_mul_next  = {w_mul_sum, r_acc[DATA_WIDTH-1:1]};
  assign w_div_shift = {r_acc[2*DATA_WIDTH-1:DATA_WIDTH], r_acc[DATA_WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opb};
  assign w_div_ge    = ~w_div_diff[DATA_WIDTH];
  assign w_div_rem   = w_div_ge ? w_div_diff[DATA_WIDTH-1:0] : w_div_shift[DATA_WIDTH-1:0];
  assign w_div_next  = {w_div_rem, r_acc[DATA_WIDTH-2:0], w_div_ge};

  // Sign fixup and result selection from the finished accumulator.
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH-1:0]   w_quo;
  logic [DATA_WIDTH-1:0]   w_rem;
  logic [DATA_WIDTH-1:0]   w_result;

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_div0  ? {DATA_WIDTH{1'b1}} :
                  (r_neg_q ? -r_acc[DATA_WIDTH-1:0] : r_acc[DATA_WIDTH-1:0]);
  assign w_rem  = r_neg_r ? -r_acc[2*DATA_WIDTH-1:DATA_WIDTH] : r_acc[2*DATA_WIDTH-1:DATA_WIDTH];

  always_comb begin
    w_result = '0;
    case (r_funct3)
      3'd0:                w_result = w_prod[DATA_WIDTH-1:0];
      3'd1, 3'd2, 3'd3:    w_result = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
      3'd4, 3'd5:          w_result = w_quo;
      default:             w_result = w_rem;
    endcase
  end

  // CALC runs DATA_WIDTH iteration cycles, then one fixup cycle (r_fix) that loads the
  // write-back registers on the edge into DONE.
  always_comb begin
    w_state_d = r_state;
    w_count_d = r_count;
    w_fix_d   = r_fix;
    w_acc_d   = r_acc;
    w_load    = 1'b0;
    w_wb_load = 1'b0;
    if (bus.kill) begin
      w_state_d = StIdle;
      w_count_d = '0;
      w_fix_d   = 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            w_state_d = StCalc;
            w_count_d = '0;
            w_fix_d   = w_early;
            w_acc_d   = w_acc_init;
            w_load    = 1'b1;
          end
        end
        StCalc: begin
          if (r_fix) begin
            w_state_d = StDone;
            w_fix_d   = 1'b0;
            w_wb_load = 1'b1;
          end else begin
            w_acc_d = r_funct3[2] ? w_div_next : w_mul_next;
            if (r_count == LastCnt) begin
              w_fix_d   = 1'b1;
              w_count_d = '0;
            end else begin
              w_count_d = r_count + 1'b1;
            end
          end
        end
        StDone: begin
          w_state_d = StIdle;
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_count   <= '0;
      r_fix     <= 1'b0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_funct3  <= '0;
      r_rd      <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_div0    <= 1'b0;
      r_wb_data <= '0;
      r_wb_rd   <= '0;
    end else begin
      r_state <= w_state_d;
      r_count <= w_count_d;
      r_fix   <= w_fix_d;
      r_acc   <= w_acc_d;
      if (w_load) begin
        r_opb    <= w_is_div ? w_b_mag : w_a_mag;
        r_funct3 <= bus.funct3;
        r_rd     <= bus.rd_in;
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
        r_div0   <= w_div0;
      end
      if (w_wb_load) begin
        r_wb_data <= w_result;
        r_wb_rd   <= r_rd;
      end
    end
  end

  // x0 is not hardwired in the register file, so never write it.
  assign bus.busy    = (r_state != StIdle);
  assign bus.done    = (r_state == StDone) & ~bus.kill;
  assign bus.wb_we   = bus.done & (r_wb_rd != 5'd0);
  assign bus.wb_rd   = r_wb_rd;
  assign bus.wb_data = r_wb_data;
endmodule
